// File: rtl/im_pkg.sv
`default_nettype none
// ============================================================================
// Module   : im_pkg
// Purpose  : Shared types and constants for the instruction-memory line
//            responder: FSM state encoding and line/word address geometry.
// Revision : 1.0 - initial release
// ============================================================================
package im_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } im_state_e;

  // Line geometry: 4 words of 32 bits, byte addressed
  localparam int LINE_WORDS   = 4;
  localparam int WORD_SEL_LSB = 2;
  localparam int TAG_LSB      = 4;

endpackage : im_pkg
`default_nettype wire

// File: rtl/im_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : im_line_buffer
// Purpose  : Single 4-word line buffer with tag and valid bit.
//            Indexed word write, combinational indexed read and tag compare.
// Ports    : clk, rst (async, active-low)
//            i_clear            - drop valid
//            i_wr_en/idx/data   - write one data word
//            i_tag_we/tag/valid - load tag and valid state
//            i_rd_idx/o_rd_data - combinational word read
//            i_cmp_tag/o_hit    - valid && tag match
// Revision : 1.0 - initial release
// ============================================================================
module im_line_buffer
  import im_pkg::*;
#(
  parameter int TAG_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_wr_en,
  input  logic [1:0]       i_wr_idx,
  input  logic [31:0]      i_wr_data,
  input  logic             i_tag_we,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_valid,
  input  logic [1:0]       i_rd_idx,
  output logic [31:0]      o_rd_data,
  input  logic [TAG_W-1:0] i_cmp_tag,
  output logic             o_hit
);

  logic [31:0]      r_data [LINE_WORDS];
  logic [TAG_W-1:0] r_tag;
  logic             r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LINE_WORDS; i++) r_data[i] <= '0;
      r_tag   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_wr_en) r_data[i_wr_idx] <= i_wr_data;
      // Clear wins over a tag load so a late invalidate is never lost
      if (i_clear)       r_valid <= 1'b0;
      else if (i_tag_we) begin
        r_tag   <= i_tag;
        r_valid <= i_valid;
      end
    end
  end

  assign o_rd_data = r_data[i_rd_idx];
  assign o_hit     = r_valid && (r_tag == i_cmp_tag);

endmodule : im_line_buffer
`default_nettype wire

// File: rtl/im_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : im_line_responder
// Purpose  : Memory-side responder for the I-cache refill interface. Serves
//            32-bit word requests from a single 4-word line buffer that is
//            refilled from the instruction SRAM on a miss.
// Ports    : clk, rst (async, active-low)
//            IM_enable/IM_address - word request (held until ready)
//            flush                - invalidate line buffer
//            IM_DO/ready/bus_err  - registered one-cycle response
//            SRAM_CS/OE/A/DO      - instruction SRAM macro (CS/OE active high)
// Revision : 1.0 - initial release
// ============================================================================
module im_line_responder
  import im_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IM_enable,
  input  logic [31:0]       IM_address,
  input  logic              flush,
  output logic [31:0]       IM_DO,
  output logic              ready,
  output logic              bus_err,
  output logic              SRAM_CS,
  output logic              SRAM_OE,
  output logic [ADDR_W-1:0] SRAM_A,
  input  logic [31:0]       SRAM_DO
);

  localparam int TAG_W = ADDR_W - 2;

  im_state_e        r_state;
  logic [TAG_W-1:0] r_tag;
  logic [1:0]       r_sel;
  logic [1:0]       r_word;
  logic [3:0]       r_wait;
  logic             r_cap_en;
  logic [1:0]       r_cap_idx;
  logic             r_flush_pend;

  logic [TAG_W-1:0] w_req_tag;
  logic [1:0]       w_req_sel;
  logic             w_oor;
  logic             w_buf_hit;
  logic             w_hit;
  logic             w_miss_start;
  logic             w_last_issue;
  logic             w_fill_done;
  logic [1:0]       w_rd_idx;
  logic [31:0]      w_rd_data;
  logic [31:0]      w_fill_word;
  logic             w_buf_clear;
  logic             w_unused;

  assign w_req_tag = IM_address[ADDR_W+1:TAG_LSB];
  assign w_req_sel = IM_address[TAG_LSB-1:WORD_SEL_LSB];
  assign w_oor     = |IM_address[31:ADDR_W+2];
  assign w_unused  = &{1'b0, IM_address[1:0]};

  // A flush in the sampling cycle forces a refill instead of a hit
  assign w_hit        = w_buf_hit && !flush && !w_oor;
  assign w_miss_start = (r_state == IDLE) && IM_enable && !w_oor && !w_hit;

  // Last cycle a word is presented; its data arrives on SRAM_DO next cycle
  assign w_last_issue = SRAM_CS && (r_wait == 4'(WAIT_CYC));
  assign w_fill_done  = (r_state == FILL) && r_cap_en && (r_cap_idx == 2'd3);

  // Word 3 is being written on the same edge the response is loaded,
  // so a request for word 3 takes it straight from the SRAM bus
  assign w_fill_word = (r_sel == 2'd3) ? SRAM_DO : w_rd_data;
  assign w_rd_idx    = (r_state == IDLE) ? w_req_sel : r_sel;

  // A flush during FILL is deferred to the tag load at fill completion
  assign w_buf_clear = (flush && (r_state != FILL)) || w_miss_start;

  im_line_buffer #(
    .TAG_W (TAG_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_buf_clear),
    .i_wr_en   (r_cap_en),
    .i_wr_idx  (r_cap_idx),
    .i_wr_data (SRAM_DO),
    .i_tag_we  (w_fill_done),
    .i_tag     (r_tag),
    .i_valid   (!(r_flush_pend || flush)),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data),
    .i_cmp_tag (w_req_tag),
    .o_hit     (w_buf_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_tag        <= '0;
      r_sel        <= '0;
      r_word       <= '0;
      r_wait       <= '0;
      r_cap_en     <= 1'b0;
      r_cap_idx    <= '0;
      r_flush_pend <= 1'b0;
      IM_DO        <= '0;
      ready        <= 1'b0;
      bus_err      <= 1'b0;
      SRAM_CS      <= 1'b0;
      SRAM_OE      <= 1'b0;
      SRAM_A       <= '0;
    end else begin
      // Response outputs are single-cycle pulses
      ready    <= 1'b0;
      bus_err  <= 1'b0;
      IM_DO    <= '0;
      r_cap_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (IM_enable) begin
            r_tag <= w_req_tag;
            r_sel <= w_req_sel;
            if (w_oor) begin
              r_state <= RESP;
              ready   <= 1'b1;
              bus_err <= 1'b1;
            end else if (w_hit) begin
              r_state <= RESP;
              ready   <= 1'b1;
              IM_DO   <= w_rd_data;
            end else begin
              r_state      <= FILL;
              r_word       <= 2'd0;
              r_wait       <= 4'd0;
              r_flush_pend <= 1'b0;
              SRAM_CS      <= 1'b1;
              SRAM_OE      <= 1'b1;
              SRAM_A       <= {w_req_tag, 2'b00};
            end
          end
        end
        FILL: begin
          if (flush) r_flush_pend <= 1'b1;
          if (SRAM_CS) begin
            if (w_last_issue) begin
              r_cap_en  <= 1'b1;
              r_cap_idx <= r_word;
              if (r_word == 2'd3) begin
                SRAM_CS <= 1'b0;
                SRAM_OE <= 1'b0;
              end else begin
                r_word <= r_word + 2'd1;
                r_wait <= 4'd0;
                SRAM_A <= {r_tag, r_word + 2'd1};
              end
            end else begin
              r_wait <= r_wait + 4'd1;
            end
          end
          if (w_fill_done) begin
            r_state <= RESP;
            ready   <= 1'b1;
            IM_DO   <= w_fill_word;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : im_line_responder
`default_nettype wire

// File: tb/tb_im_line_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_im_line_responder
// Purpose  : Self-checking bench for im_line_responder. Instance 1 uses no
//            wait states, instance 2 uses two wait states per SRAM read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_im_line_responder;

  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic en1 = 1'b0, en2 = 1'b0;
  logic [31:0] addr1 = '0, addr2 = '0;
  logic [31:0] do1, do2, sdo1, sdo2;
  logic rdy1, rdy2, err1, err2, cs1, cs2, oe1, oe2;
  logic [AW-1:0] a1, a2;

  int gen = 0;
  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int rdy_cnt1 = 0;

  typedef struct { int cyc; logic [AW-1:0] a; } rd_t;
  typedef struct { logic [31:0] d; logic e; int lat; } exp_t;
  rd_t  log1[$];
  rd_t  log2[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  im_line_responder #(.ADDR_W(AW), .WAIT_CYC(0)) dut1 (
    .clk(clk), .rst(rst), .IM_enable(en1), .IM_address(addr1), .flush(flush),
    .IM_DO(do1), .ready(rdy1), .bus_err(err1),
    .SRAM_CS(cs1), .SRAM_OE(oe1), .SRAM_A(a1), .SRAM_DO(sdo1)
  );

  im_line_responder #(.ADDR_W(AW), .WAIT_CYC(2)) dut2 (
    .clk(clk), .rst(rst), .IM_enable(en2), .IM_address(addr2), .flush(flush),
    .IM_DO(do2), .ready(rdy2), .bus_err(err2),
    .SRAM_CS(cs2), .SRAM_OE(oe2), .SRAM_A(a2), .SRAM_DO(sdo2)
  );

  // SRAM contents: word address plus a generation field that tests bump
  function automatic logic [31:0] sram_val(input logic [AW-1:0] wa);
    return 32'hA000_0000 + (32'(gen) << 16) + 32'(wa);
  endfunction

  function automatic logic is_oor(input logic [31:0] a);
    return a[31:AW+2] != '0;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (is_oor(a)) return 32'h0;
    return sram_val(a[AW+1:2]);
  endfunction

  // SRAM macro models: data one cycle after select, junk otherwise
  always @(posedge clk) begin
    cyc++;
    sdo1 <= (cs1 && oe1) ? sram_val(a1) : 32'hDEAD_BEEF;
    sdo2 <= (cs2 && oe2) ? sram_val(a2) : 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    if (cs1) log1.push_back('{cyc, a1});
    if (cs2) log2.push_back('{cyc, a2});
    if (rdy1) rdy_cnt1++;
  end

  // Drive one request and wait (bounded) for its response.
  // lat = cycles from the drive point to the ready sample.
  task automatic drive_req(input bit sel, input logic [31:0] a,
                           output int lat, output logic [31:0] d, output logic e);
    lat = 0;
    if (sel) begin en2 = 1'b1; addr2 = a; end
    else     begin en1 = 1'b1; addr1 = a; end
    do begin
      @(negedge clk);
      lat++;
    end while (!(sel ? rdy2 : rdy1) && lat < 40);
    d = sel ? do2 : do1;
    e = sel ? err2 : err1;
    if (sel) en2 = 1'b0; else en1 = 1'b0;
  endtask

  task automatic test_reset();
    en1 = 1'b1; addr1 = 32'h104;
    en2 = 1'b1; addr2 = 32'h104;
    repeat (3) @(negedge clk);
    n_total++;
    if ({rdy1, err1, cs1, oe1} !== 4'b0) $display("FAIL reset_ctl1 got %b required 0000", {rdy1, err1, cs1, oe1});
    else n_pass++;
    n_total++;
    if (do1 !== 32'h0 || a1 !== '0) $display("FAIL reset_data1 got do=%h a=%h required 0", do1, a1);
    else n_pass++;
    n_total++;
    if ({rdy2, err2, cs2, oe2, a2, do2} !== '0) $display("FAIL reset_dut2 got rdy=%b cs=%b do=%h required 0", rdy2, cs2, do2);
    else n_pass++;
    en1 = 1'b0; en2 = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    logic [31:0] addrs[4];
    int          lats[4];
    int lat, c0;
    logic [31:0] d;
    logic e;
    exp_t x;
    addrs = '{32'h104, 32'h100, 32'h108, 32'h10C};
    lats  = '{6, 2, 2, 2};   // hits driven in the ready cycle sample one cycle later
    @(negedge clk);
    log1.delete();
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{exp_word(addrs[i]), 1'b0, lats[i]});
      drive_req(1'b0, addrs[i], lat, d, e);
      x = sb.pop_front();
      n_total++;
      if (d !== x.d || e !== x.e) $display("FAIL cold_data[%0d] got %h/%b required %h/%b", i, d, e, x.d, x.e);
      else n_pass++;
      n_total++;
      if (lat !== x.lat) $display("FAIL cold_lat[%0d] got %0d required %0d", i, lat, x.lat);
      else n_pass++;
    end
    n_total++;
    if (log1.size() !== 4) $display("FAIL cold_nreads got %0d required 4", log1.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < log1.size(); k++) begin
      n_total++;
      if (log1[k].a !== AW'(32'h40 + k) || log1[k].cyc !== c0 + 1 + k)
        $display("FAIL cold_read[%0d] got a=%h cyc=%0d required a=%h cyc=%0d",
                 k, log1[k].a, log1[k].cyc, AW'(32'h40 + k), c0 + 1 + k);
      else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs[2];
    int          lats[2];
    int lat;
    logic [31:0] d;
    logic e;
    exp_t x;
    addrs = '{32'h0001_0000, 32'h10C};
    lats  = '{1, 2};
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{exp_word(addrs[i]), is_oor(addrs[i]), lats[i]});
      drive_req(1'b0, addrs[i], lat, d, e);
      x = sb.pop_front();
      n_total++;
      if (d !== x.d || e !== x.e) $display("FAIL oor_data[%0d] got %h/%b required %h/%b", i, d, e, x.d, x.e);
      else n_pass++;
      n_total++;
      if (lat !== x.lat) $display("FAIL oor_lat[%0d] got %0d required %0d", i, lat, x.lat);
      else n_pass++;
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] addrs[2];
    int          lats[2];
    int lat, c0;
    logic [31:0] d;
    logic e;
    exp_t x;
    addrs = '{32'h104, 32'h10C};
    lats  = '{14, 2};
    @(negedge clk);
    log2.delete();
    c0 = cyc;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{exp_word(addrs[i]), 1'b0, lats[i]});
      drive_req(1'b1, addrs[i], lat, d, e);
      x = sb.pop_front();
      n_total++;
      if (d !== x.d || e !== x.e) $display("FAIL wait_data[%0d] got %h/%b required %h/%b", i, d, e, x.d, x.e);
      else n_pass++;
      n_total++;
      if (lat !== x.lat) $display("FAIL wait_lat[%0d] got %0d required %0d", i, lat, x.lat);
      else n_pass++;
    end
    n_total++;
    if (log2.size() !== 12) $display("FAIL wait_nreads got %0d required 12", log2.size());
    else n_pass++;
    for (int k = 0; k < 12 && k < log2.size(); k++) begin
      n_total++;
      if (log2[k].a !== AW'(32'h40 + k / 3) || log2[k].cyc !== c0 + 1 + k)
        $display("FAIL wait_read[%0d] got a=%h cyc=%0d required a=%h cyc=%0d",
                 k, log2[k].a, log2[k].cyc, AW'(32'h40 + k / 3), c0 + 1 + k);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    int lat;
    logic [31:0] d;
    logic e;
    exp_t x;
    // Flush pulsed while the line is filling
    @(negedge clk);
    sb.push_back('{exp_word(32'h208), 1'b0, 6});
    fork
      drive_req(1'b0, 32'h208, lat, d, e);
      begin
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    x = sb.pop_front();
    n_total++;
    if (d !== x.d || lat !== x.lat) $display("FAIL flush_fill got %h lat %0d required %h lat %0d", d, lat, x.d, x.lat);
    else n_pass++;
    // Same line again must refill; new generation proves fresh SRAM data
    gen = 1;
    log1.delete();
    sb.push_back('{exp_word(32'h20C), 1'b0, 7});
    drive_req(1'b0, 32'h20C, lat, d, e);
    x = sb.pop_front();
    n_total++;
    if (d !== x.d || lat !== x.lat) $display("FAIL flush_refill got %h lat %0d required %h lat %0d", d, lat, x.d, x.lat);
    else n_pass++;
    n_total++;
    if (log1.size() !== 4 || log1[0].a !== AW'(32'h80)) $display("FAIL flush_reads got %0d reads required 4 from 080", log1.size());
    else n_pass++;
    // Flush coincident with a would-be hit turns it into a miss
    @(negedge clk);
    gen = 2;
    flush = 1'b1;
    sb.push_back('{exp_word(32'h200), 1'b0, 6});
    fork
      drive_req(1'b0, 32'h200, lat, d, e);
      begin
        @(negedge clk);
        flush = 1'b0;
      end
    join
    x = sb.pop_front();
    n_total++;
    if (d !== x.d || lat !== x.lat) $display("FAIL flush_hit got %h lat %0d required %h lat %0d", d, lat, x.d, x.lat);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    int lat, n, rc0;
    bit found;
    logic [31:0] d;
    logic e;
    exp_t x;
    @(negedge clk);
    rc0 = rdy_cnt1;
    n = 0;
    found = 1'b0;
    en1 = 1'b1; addr1 = 32'h304;
    while (n < 20 && !found) begin
      @(negedge clk);
      n++;
      if (cs1 && a1 == AW'(32'hC2)) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL rmf_reach got no word-2 issue required word-2 issue");
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if ({rdy1, cs1, oe1} !== 3'b0 || a1 !== '0) $display("FAIL rmf_abort got rdy=%b cs=%b a=%h required 0", rdy1, cs1, a1);
    else n_pass++;
    repeat (2) @(negedge clk);
    en1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (rdy_cnt1 !== rc0) $display("FAIL rmf_noready got %0d pulses required 0", rdy_cnt1 - rc0);
    else n_pass++;
    log1.delete();
    sb.push_back('{exp_word(32'h304), 1'b0, 6});
    drive_req(1'b0, 32'h304, lat, d, e);
    x = sb.pop_front();
    n_total++;
    if (d !== x.d || lat !== x.lat) $display("FAIL rmf_refill got %h lat %0d required %h lat %0d", d, lat, x.d, x.lat);
    else n_pass++;
    n_total++;
    if (log1.size() !== 4) $display("FAIL rmf_nreads got %0d required 4", log1.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < log1.size(); k++) begin
      n_total++;
      if (log1[k].a !== AW'(32'hC0 + k)) $display("FAIL rmf_read[%0d] got %h required %h", k, log1[k].a, AW'(32'hC0 + k));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_out_of_range();
    test_wait_states();
    test_flush();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion required completion within 200us");
    $fatal(1);
  end

endmodule : tb_im_line_responder
`default_nettype wire
